// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, widths and opcodes for the ALU sequencer
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OPC_NEG  = 3'b000;
  localparam logic [2:0] OPC_INC  = 3'b001;
  localparam logic [2:0] OPC_ADC  = 3'b010;
  localparam logic [2:0] OPC_ADDH = 3'b011;
  localparam logic [2:0] OPC_AND  = 3'b100;
  localparam logic [2:0] OPC_OR   = 3'b101;
  localparam logic [2:0] OPC_CAT  = 3'b110;
  localparam logic [2:0] OPC_ZERO = 3'b111;

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational 16-bit ALU with zero/negative flags
module alu_sequencer_alu
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c,
  input  logic [2:0]        opc,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              neg
);

  localparam int HALF_W = DATA_W / 2;

  logic [DATA_W-1:0] b_half;

  // Arithmetic shift keeps the sign of B, so 0x8000 halves to 0xC000.
  assign b_half = DATA_W'($signed(b) >>> 1);

  always_comb begin
    y = '0;
    case (opc)
      OPC_NEG:  y = DATA_W'(0) - a;
      OPC_INC:  y = a + DATA_W'(1);
      OPC_ADC:  y = a + b + DATA_W'(c);
      OPC_ADDH: y = a + b_half;
      OPC_AND:  y = a & b;
      OPC_OR:   y = a | b;
      OPC_CAT:  y = {a[HALF_W-1:0], b[HALF_W-1:0]};
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);
  assign neg  = y[DATA_W-1];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - iterates one ALU opcode over an accumulator and returns the result
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opc,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_c,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              cmd_soz,
  input  logic              abort,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_neg,
  output logic [CNT_W-1:0]  res_iters,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        opc_q, opc_d;
  logic              c_q, c_d;
  logic              soz_q, soz_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  iters_q, iters_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;
  logic              res_neg_q, res_neg_d;
  logic [CNT_W-1:0]  res_iters_q, res_iters_d;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              alu_neg;

  alu_sequencer_alu u_alu (
    .a    (acc_q),
    .b    (b_q),
    .c    (c_q),
    .opc  (opc_q),
    .y    (alu_y),
    .zero (alu_zero),
    .neg  (alu_neg)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    opc_d       = opc_q;
    c_d         = c_q;
    soz_d       = soz_q;
    rem_d       = rem_q;
    iters_d     = iters_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    res_iters_d = res_iters_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          acc_d   = cmd_a;
          b_d     = cmd_b;
          opc_d   = cmd_opc;
          c_d     = cmd_c;
          soz_d   = cmd_soz;
          rem_d   = cmd_cnt;
          iters_d = '0;
          if (cmd_cnt == '0) begin
            state_d     = DONE;
            res_data_d  = cmd_a;
            res_zero_d  = (cmd_a == '0);
            res_neg_d   = cmd_a[DATA_W-1];
            res_iters_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Abort outranks a completing iteration: nothing is published.
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = alu_y;
          rem_d   = rem_q - CNT_W'(1);
          iters_d = iters_q + CNT_W'(1);
          if ((rem_q == CNT_W'(1)) || (soz_q && alu_zero)) begin
            state_d     = DONE;
            res_data_d  = alu_y;
            res_zero_d  = alu_zero;
            res_neg_d   = alu_neg;
            res_iters_d = iters_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      opc_q       <= '0;
      c_q         <= 1'b0;
      soz_q       <= 1'b0;
      rem_q       <= '0;
      iters_q     <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b1;
      res_neg_q   <= 1'b0;
      res_iters_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      opc_q       <= opc_d;
      c_q         <= c_d;
      soz_q       <= soz_d;
      rem_q       <= rem_d;
      iters_q     <= iters_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
      res_iters_q <= res_iters_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_neg   = res_neg_q;
  assign res_iters = res_iters_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opc;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_c;
  logic [3:0]  cmd_cnt;
  logic        cmd_soz;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_zero;
  logic        res_neg;
  logic [3:0]  res_iters;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        neg;
    logic [3:0]  iters;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [15:0] last_data;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opc   (cmd_opc),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_cnt   (cmd_cnt),
    .cmd_soz   (cmd_soz),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_neg   (res_neg),
    .res_iters (res_iters),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic c, input logic [2:0] opc);
    logic [16:0] s;
    case (opc)
      3'd0: return ~a + 16'd1;
      3'd1: return a + 16'd1;
      3'd2: begin s = {1'b0, a} + {1'b0, b} + {16'd0, c}; return s[15:0]; end
      3'd3: return a + {b[15], b[15:1]};
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return {a[7:0], b[7:0]};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic [3:0] cnt, input logic soz);
    exp_t e;
    logic [15:0] acc;
    int it;
    acc = a;
    it  = 0;
    for (int i = 0; i < cnt; i++) begin
      acc = model_alu(acc, b, c, opc);
      it++;
      if (soz && acc == 16'h0000) break;
    end
    e.data  = acc;
    e.zero  = (acc == 16'h0000);
    e.neg   = acc[15];
    e.iters = it[3:0];
    e.lat   = (it == 0) ? 8'd1 : it[7:0];
    return e;
  endfunction

  // Drives one command and consumes the accept edge; leaves inputs idle at posedge+1.
  task automatic start_cmd(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [3:0] cnt, input logic soz);
    chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_opc   = opc;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = c;
    cmd_cnt   = cnt;
    cmd_soz   = soz;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [3:0] cnt, input logic soz, input bit hold);
    exp_t e;
    int   lat;
    logic [15:0] d0;
    sb_q.push_back(model(opc, a, b, c, cnt, soz));
    start_cmd(opc, a, b, c, cnt, soz);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!res_valid && lat < 40);
    chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("latency", lat, {24'd0, e.lat});
      chk("res_data", {16'd0, res_data}, {16'd0, e.data});
      chk("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
      chk("res_neg", {31'd0, res_neg}, {31'd0, e.neg});
      chk("res_iters", {28'd0, res_iters}, {28'd0, e.iters});
      last_data = e.data;
    end
    if (hold) begin
      d0        = res_data;
      cmd_valid = 1'b1;
      cmd_a     = ~a;
      cmd_cnt   = 4'd0;
      abort     = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, res_valid}, 32'd1);
        chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("hold_data", {16'd0, res_data}, {16'd0, d0});
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("release_valid", {31'd0, res_valid}, 32'd0);
    chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_data = 16'h0000;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_opc   = 3'd0;
    cmd_a     = 16'h0;
    cmd_b     = 16'h0;
    cmd_c     = 1'b0;
    cmd_cnt   = 4'd0;
    cmd_soz   = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_res_zero", {31'd0, res_zero}, 32'd1);
    chk("rst_res_neg", {31'd0, res_neg}, 32'd0);
    chk("rst_res_iters", {28'd0, res_iters}, 32'd0);
    rst_n = 1'b1;

    run_cmd(3'b001, 16'h0005, 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0);
    run_cmd(3'b010, 16'h7FFF, 16'h0001, 1'b1, 4'd1, 1'b0, 1'b0);
    run_cmd(3'b010, 16'h1234, 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0);
    run_cmd(3'b001, 16'hFFFE, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b0);
    run_cmd(3'b011, 16'h0000, 16'h8000, 1'b0, 4'd2, 1'b0, 1'b0);
    run_cmd(3'b000, 16'h0003, 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0);
    run_cmd(3'b010, 16'hFFFF, 16'hFFFF, 1'b1, 4'd15, 1'b0, 1'b0);
    run_cmd(3'b110, 16'h12AB, 16'h34CD, 1'b0, 4'd2, 1'b0, 1'b0);
    run_cmd(3'b111, 16'h5555, 16'h0000, 1'b0, 4'd9, 1'b1, 1'b0);
    run_cmd(3'b100, 16'hF0F0, 16'h3C3C, 1'b0, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom),
              4'($urandom_range(0, 6)), 1'($urandom), 1'b0);
    end

    // Abort on the second RUN edge of a long command.
    start_cmd(3'b001, 16'h0100, 16'h0000, 1'b0, 4'd10, 1'b0);
    @(posedge clk);
    #1;
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_data_kept", {16'd0, res_data}, {16'd0, last_data});
    run_cmd(3'b101, 16'h00F0, 16'h0F00, 1'b0, 4'd2, 1'b0, 1'b0);

    // Abort coinciding with the final iteration.
    start_cmd(3'b001, 16'h0010, 16'h0000, 1'b0, 4'd2, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_last_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_last_busy", {31'd0, busy}, 32'd0);
    run_cmd(3'b001, 16'h0005, 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0);

    // Reset on the second RUN edge.
    start_cmd(3'b001, 16'h0200, 16'h0000, 1'b0, 4'd10, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_data", {16'd0, res_data}, 32'd0);
    chk("midrst_zero", {31'd0, res_zero}, 32'd1);
    chk("midrst_iters", {28'd0, res_iters}, 32'd0);
    run_cmd(3'b011, 16'h0000, 16'h8000, 1'b0, 4'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Ports SHALL be: clk  in  1  single clock, all state updates on its rising edge.
REQ-002 rst_n  in  1  reset, synchronous and active-low.
REQ-003 cmd_valid  in  1  command offered; cmd_ready  out  1  sequencer can accept a command.
REQ-004 cmd_opc  in  3  ALU opcode; cmd_a  in  16  initial accumulator; cmd_b  in  16  fixed B operand; cmd_c  in  1  fixed carry-in.
REQ-005 cmd_cnt  in  4  iteration count (0-15); cmd_soz  in  1  stop-on-zero enable.
REQ-006 abort  in  1  cancel the running command.
REQ-007 res_valid  out  1  result available; res_ready  in  1  consumer takes the result.
REQ-008 res_data  out  16  final accumulator; res_zero, res_neg  out  1 each  flags of res_data; res_iters  out  4  iterations actually executed.
REQ-009 busy  out  1  high in any state other than IDLE.

Function
REQ-010 States SHALL be IDLE, RUN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-011 A command SHALL be accepted on an edge with cmd_valid=1 in IDLE; at that edge acc<=cmd_a, opc/b/c/soz are latched, remaining<=cmd_cnt and iters<=0.
REQ-012 On acceptance with cmd_cnt=0 the next state SHALL be DONE, with res_data=cmd_a; otherwise the next state SHALL be RUN.
REQ-013 On each RUN edge: acc<=ALU(acc, b, c, opc); remaining<=remaining-1; iters<=iters+1.
REQ-014 The ALU SHALL execute opcodes as: 000 two's-complement negate A; 001 A+1; 010 A+B+C; 011 A+(B>>>1) arithmetic; 100 A&B; 101 A|B; 110 {A[7:0],B[7:0]}; 111 zero.
REQ-015 All arithmetic SHALL be 16-bit modulo 2^16 with no overflow flag; carry-out SHALL be discarded, and cmd_c SHALL be reused unchanged on every iteration.
REQ-016 RUN SHALL go to DONE on the edge where remaining reaches 0.
REQ-017 With soz=1, RUN SHALL go to DONE on the edge where the new acc is 0x0000, even if remaining is non-zero.
REQ-018 Latency: res_valid SHALL rise exactly N cycles after the accept edge, where N is the number of iterations executed; for cnt=0 it rises 1 cycle after the accept edge.
REQ-019 In DONE, res_valid=1 and res_data/res_zero/res_neg/res_iters SHALL hold stable until an edge with res_ready=1, which returns the state to IDLE.
REQ-020 res_zero SHALL equal (res_data==0) and res_neg SHALL equal res_data[15].
REQ-021 abort=1 in RUN SHALL return the state to IDLE at that edge with no res_valid pulse; abort SHALL be ignored in IDLE and DONE.
REQ-022 If abort and the final iteration coincide, abort SHALL win.
REQ-023 cmd_valid in RUN or DONE SHALL be ignored (not accepted, no state change).
REQ-024 When not in DONE, res_valid SHALL be 0, and res_data SHALL retain its last value.

Reset
REQ-025 An edge with rst_n=0 SHALL force: state IDLE, cmd_ready=1, res_valid=0, busy=0, res_data=0x0000, res_zero=1, res_neg=0, res_iters=0, acc=0, remaining=0.
REQ-026 Reset SHALL take priority over abort, acceptance and handshakes in every state, including mid-RUN; the command in progress SHALL be discarded.

Structure
REQ-027 A shared package alu_seq_pkg SHALL hold the state enum (IDLE/RUN/DONE), the eight opcode constants, and the data width (16) and count width (4) parameters.
REQ-028 The team's existing combinational 16-bit ALU SHALL be the single sub-module, with its A input driven by acc and B, C and opc driven by the latched command.
REQ-029 The ALU's zero/neg outputs SHALL feed the stop-on-zero decision; the result flags SHALL be registered.

Verification
REQ-030 opc=001, a=0x0005, cnt=3, soz=0 -> res_data=0x0008, zero=0, neg=0, iters=3, res_valid 3 cycles after accept.
REQ-031 opc=010, a=0x7FFF, b=0x0001, c=1, cnt=1 -> res_data=0x8001, neg=1; cnt=0, a=0x1234 -> res_data=0x1234 one cycle after accept, iters=0.
REQ-032 opc=001, a=0xFFFE, cnt=5, soz=1 -> early stop, res_data=0x0000, zero=1, iters=2.
REQ-033 opc=011, a=0x0000, b=0x8000, cnt=2 -> res_data=0x8000 (0xC000 added twice, mod 2^16), neg=1.
REQ-034 Hold res_ready=0 for 4 cycles in DONE with cmd_valid=1 -> outputs stable, cmd_ready=0, no accept; res_ready=1 -> IDLE next edge.
REQ-035 Both of the following -> IDLE next edge, no res_valid, subsequent command executes correctly: abort asserted on the 2nd RUN cycle of cnt=10; rst_n=0 on the 2nd RUN cycle of cnt=10.
